// File: rtl/mem_pkg.sv
// Shared definitions for the line-refill memory responder.
//   ADDR_W : default line address width (2^ADDR_W lines)
//   LINE_W : default line width (4 words)
//   WORD_W : preload word width
//   LAT_W  : width of the latency down-counter (LATENCY 1..15)
//   resp_state_t : responder FSM states
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    RESP
  } resp_state_t;

endpackage

// File: rtl/mem_line_array.sv
// Line storage for the refill responder.
//   clk, reset_n : clock, synchronous active-low reset (read register only)
//   i_we, i_waddr, i_wordid, i_wdata : 32-bit word write port
//   i_rd_en, i_raddr : full-line capture strobe and address
//   o_rdata : registered captured line (cleared by reset)
// Storage itself is not reset. A write and a capture on the same edge to
// the same line return the pre-write contents.
module mem_line_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int LINE_W = mem_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [1:0]        i_wordid,
  input  logic [31:0]       i_wdata,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [2**ADDR_W];
  logic [LINE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr][WORD_W*int'(i_wordid) +: WORD_W] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side responder for the cache line-refill protocol.
//   clk, reset_n   : clock, synchronous active-low reset
//   mem_req_i      : level-held line request (4-phase handshake)
//   mem_addr_i     : line address, sampled only at acceptance
//   mem_data_o     : returned line, word w at [32w+31:32w]
//   mem_comp_o     : completion, held until the request is withdrawn
//   busy_o         : high whenever the FSM is not IDLE
//   init_*         : word-granular preload port, active in every state
//   req_count_o    : accepted-request count, wraps modulo 2^16
// Completion rises LATENCY edges after the acceptance edge.
module line_fill_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int LINE_W  = mem_pkg::LINE_W,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_comp_o,
  output logic              busy_o,
  input  logic              init_we_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [1:0]        init_wordid_i,
  input  logic [31:0]       init_data_i,
  output logic [15:0]       req_count_o
);

  resp_state_t       r_state;
  resp_state_t       w_state_nxt;
  logic [LAT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_req_count;
  logic              r_comp;
  logic              r_busy;
  logic              w_accept;
  logic              w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_req_i) begin
          w_state_nxt = LAT;
          w_accept    = 1'b1;
        end
      end
      LAT: begin
        // Withdrawal wins over an expiring counter: no completion on abort.
        if (!mem_req_i) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = RESP;
          w_capture   = 1'b1;
        end
      end
      RESP: begin
        if (!mem_req_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // comp/busy are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_req_count <= '0;
      r_comp      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_comp <= (w_state_nxt == RESP);
      r_busy <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_addr      <= mem_addr_i;
        r_cnt       <= LAT_W'(LATENCY - 1);
        r_req_count <= r_req_count + 16'd1;
      end else if (r_state == LAT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  mem_line_array #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_we     (init_we_i),
    .i_waddr  (init_addr_i),
    .i_wordid (init_wordid_i),
    .i_wdata  (init_data_i),
    .i_rd_en  (w_capture),
    .i_raddr  (r_addr),
    .o_rdata  (mem_data_o)
  );

  assign mem_comp_o  = r_comp;
  assign busy_o      = r_busy;
  assign req_count_o = r_req_count;

endmodule
